// File: rtl/activation_pipe.sv
// Per-lane rescale + activation (sat-ReLU / clip / leaky ReLU) with saturation counter.
// Two register stages, 1 beat/cycle; out_valid && !out_ready freezes both stages and drops in_ready.
module activation_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 16,
    parameter int SHIFT_W   = $clog2(IN_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_WIDTH-1:0]    in_data,
    input  logic                         in_last,
    input  logic [1:0]                   mode,
    input  logic [SHIFT_W-1:0]           shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_WIDTH-1:0]   out_data,
    output logic                         out_last,
    output logic [CNT_WIDTH-1:0]         sat_count,
    input  logic                         clear_count
);

    localparam logic signed [IN_WIDTH-1:0] MAX_V = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] MIN_V = ~MAX_V;

    logic                          en;
    logic [SHIFT_W:0]              shift3;
    logic signed [IN_WIDTH-1:0]    lane_x [LANES];
    logic signed [IN_WIDTH-1:0]    s_d    [LANES];
    logic signed [IN_WIDTH-1:0]    n_d    [LANES];

    logic                          vld1_q;
    logic [1:0]                    mode1_q;
    logic                          last1_q;
    logic signed [IN_WIDTH-1:0]    s_q    [LANES];
    logic signed [IN_WIDTH-1:0]    n_q    [LANES];

    logic [LANES*OUT_WIDTH-1:0]    out_data_d;
    logic [LANES-1:0]              sat_vec;
    logic [CNT_WIDTH:0]            cnt_sum;
    logic [CNT_WIDTH-1:0]          sat_count_d;

    logic                          out_valid_q;
    logic [LANES*OUT_WIDTH-1:0]    out_data_q;
    logic                          out_last_q;
    logic [CNT_WIDTH-1:0]          sat_count_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Extra width keeps shift+3 from wrapping; shifts past the width fill with the sign bit.
    assign shift3 = {1'b0, shift} + (SHIFT_W + 1)'(3);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_x[i] = in_data[i*IN_WIDTH +: IN_WIDTH];
            s_d[i]    = lane_x[i] >>> shift;
            n_d[i]    = lane_x[i] >>> shift3;
        end
    end

    always_comb begin
        out_data_d = '0;
        sat_vec    = '0;
        for (int i = 0; i < LANES; i++) begin
            case (mode1_q)
                2'b00: begin
                    if (s_q[i] <= 0) begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = '0;
                    end else if (s_q[i] > MAX_V) begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = MAX_V[OUT_WIDTH-1:0];
                        sat_vec[i] = 1'b1;
                    end else begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = s_q[i][OUT_WIDTH-1:0];
                    end
                end
                2'b01: begin
                    if (s_q[i] > MAX_V) begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = MAX_V[OUT_WIDTH-1:0];
                        sat_vec[i] = 1'b1;
                    end else if (s_q[i] < MIN_V) begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = MIN_V[OUT_WIDTH-1:0];
                        sat_vec[i] = 1'b1;
                    end else begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = s_q[i][OUT_WIDTH-1:0];
                    end
                end
                2'b10: begin
                    // Negative side uses the extra /8 slope precomputed in stage 1.
                    if (!s_q[i][IN_WIDTH-1]) begin
                        if (s_q[i] > MAX_V) begin
                            out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = MAX_V[OUT_WIDTH-1:0];
                            sat_vec[i] = 1'b1;
                        end else begin
                            out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = s_q[i][OUT_WIDTH-1:0];
                        end
                    end else if (n_q[i] < MIN_V) begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = MIN_V[OUT_WIDTH-1:0];
                        sat_vec[i] = 1'b1;
                    end else begin
                        out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = n_q[i][OUT_WIDTH-1:0];
                    end
                end
                default: begin
                    out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_sum = {1'b0, sat_count_q};
        for (int i = 0; i < LANES; i++) begin
            cnt_sum = cnt_sum + {{CNT_WIDTH{1'b0}}, sat_vec[i]};
        end
        sat_count_d = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q      <= 1'b0;
            mode1_q     <= 2'b00;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_count_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s_q[i] <= '0;
                n_q[i] <= '0;
            end
        end else begin
            if (en) begin
                vld1_q <= in_valid;
                if (in_valid) begin
                    mode1_q <= mode;
                    last1_q <= in_last;
                    for (int i = 0; i < LANES; i++) begin
                        s_q[i] <= s_d[i];
                        n_q[i] <= n_d[i];
                    end
                end
                out_valid_q <= vld1_q;
                if (vld1_q) begin
                    out_data_q <= out_data_d;
                    out_last_q <= last1_q;
                end
            end
            if (clear_count) begin
                sat_count_q <= '0;
            end else if (en && vld1_q) begin
                sat_count_q <= sat_count_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe: per-mode vectors, stall/order stream, reset, clear and counter saturation.
module tb_activation_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [1:0]   mode;
    logic [4:0]   shift;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [15:0]  sat_count;
    logic         clear_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    activation_pipe #(
        .IN_WIDTH(32), .OUT_WIDTH(8), .LANES(4), .CNT_WIDTH(16), .SHIFT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mode(mode), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sat_count(sat_count), .clear_count(clear_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    // Present one beat, then wait (bounded) for it at the output and compare.
    task automatic beat(input string tag, input logic [1:0] m, input logic [4:0] sh,
                        input int a, input int b, input int c, input int d,
                        input logic [31:0] exp, input logic [15:0] exp_cnt);
        int k;
        in_valid = 1'b1;
        mode     = m;
        shift    = sh;
        in_data  = pack4(a, b, c, d);
        in_last  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        k = 0;
        while (!out_valid && k < 4) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_dat"}, out_data, exp);
        chk({tag, "_cnt"}, 32'(sat_count), 32'(exp_cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_s [6];
        logic        held_vld;
        logic [31:0] held_dat;
        logic        fire_in;
        logic        fire_out;
        int          sent;
        int          recv;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        mode        = 2'b00;
        shift       = '0;
        out_ready   = 1'b1;
        clear_count = 1'b0;
        #12;
        chk("rst_vld",  32'(out_valid), 32'd0);
        chk("rst_dat",  out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_cnt",  32'(sat_count), 32'd0);
        chk("rst_rdy",  32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        beat("relu",   2'b00, 5'd0,  -5, 0, 100, 300,         32'h7F640000, 16'd1);
        beat("clip",   2'b01, 5'd0,  -200, -128, 50, 128,     32'h7F328080, 16'd3);
        beat("leaky",  2'b10, 5'd0,  -80, -2000, 7, -1,       32'hFF0780F6, 16'd4);
        beat("rsvd",   2'b11, 5'd0,  1000, -1000, 5, 0,       32'h00000000, 16'd4);
        beat("relu_sh",2'b00, 5'd4,  1600, 4096, 15, -16,     32'h00007F64, 16'd5);
        beat("sh31",   2'b00, 5'd31, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
             32'h00000000, 16'd5);
        beat("lk_big", 2'b10, 5'd31, 32'h80000000, 32'h80000000, -1, 32'h80000000,
             32'hFFFFFFFF, 16'd5);

        // Six-beat stream with a 3-cycle downstream stall; shift alternates per beat.
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < 4; l++) begin
                exp_s[k][l*8 +: 8] = 8'((k * 20 + l * 2) >> (k % 2));
            end
        end
        sent = 0;
        recv = 0;
        held_vld = 1'b0;
        held_dat = '0;
        mode = 2'b01;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            in_valid  = (sent < 6);
            shift     = 5'(sent % 2);
            in_data   = pack4(sent * 20, sent * 20 + 2, sent * 20 + 4, sent * 20 + 6);
            in_last   = (sent == 5);
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            chk("s_rdy", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (held_vld) chk("s_hold", out_data, held_dat);
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            held_vld = out_valid && !out_ready;
            held_dat = out_data;
            if (fire_out) begin
                chk("s_dat",  out_data, exp_s[recv]);
                chk("s_last", 32'(out_last), 32'(recv == 5));
                recv++;
            end
            @(posedge clk); #1;
            if (fire_in) sent++;
        end
        chk("s_recv", 32'(recv), 32'd6);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with two saturating beats in flight.
        mode     = 2'b01;
        shift    = '0;
        in_data  = pack4(1000, 1000, 1000, 1000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mr_pre_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_cnt", 32'(sat_count), 32'd0);
        chk("mr_dat", out_data, 32'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("mr_stale", 32'(out_valid), 32'd0);
        end

        // Clear coincides with the saturating beat reaching the counter.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        chk("clr_cnt", 32'(sat_count), 32'd0);
        @(posedge clk); #1;
        chk("clr_hold", 32'(sat_count), 32'd0);

        // 17500 beats x 4 saturated lanes = 70000 events.
        in_valid = 1'b1;
        repeat (17500) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_stick", 32'(sat_count), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
